// File: rtl/motion_pkg.sv
// Shared definitions for the multi-zone motion lighting controller:
// zone state encoding, override mode codes and the relay drive rule.
package motion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } zone_state_t;

   localparam logic [1:0] MODE_AUTO = 2'b00;
   localparam logic [1:0] MODE_ON   = 2'b01;
   localparam logic [1:0] MODE_OFF  = 2'b10;

   // Relay drive for a zone given its override mode and whether the zone
   // will be occupied after this edge; the unused code 11 behaves as auto.
   function automatic logic lightDrive(input logic [1:0] mode, input logic busy);
      case (mode)
         MODE_AUTO: return busy;
         MODE_ON:   return 1'b1;
         MODE_OFF:  return 1'b0;
         default:   return busy;
      endcase
   endfunction

endpackage

// File: rtl/motion_zone.sv
// One lighting zone: two-flop synchroniser, debounce filter, occupancy
// state machine with a retriggerable hold timer, and registered outputs.
module motion_zone #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_TICKS      = 30,
   parameter int TIMER_W         = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tick,
   input  logic       i_motion,
   input  logic [1:0] i_mode,
   output logic       o_lights_on,
   output logic       o_occupied,
   output logic       o_timeout_pulse
);
   import motion_pkg::*;

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_TICKS);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

   logic              r_syncStage1;
   logic              r_syncStage2;
   logic              r_filtered;
   logic [DB_W-1:0]   r_dbCount;
   zone_state_t       r_state;
   logic [TIMER_W-1:0] r_timer;
   logic              r_lightsOn;
   logic              r_occupied;
   logic              r_timeoutPulse;

   // Bring the raw PIR pin into the clock domain through two flops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_syncStage1 <= 1'b0;
         r_syncStage2 <= 1'b0;
      end else begin
         r_syncStage1 <= i_motion;
         r_syncStage2 <= r_syncStage1;
      end
   end

   // Accept a new motion level only after it has persisted long enough.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dbCount  <= '0;
         r_filtered <= 1'b0;
      end else if (r_syncStage2 != r_filtered) begin
         if (r_dbCount == DB_LAST) begin
            r_filtered <= r_syncStage2;
            r_dbCount  <= '0;
         end else begin
            r_dbCount <= r_dbCount + 1'b1;
         end
      end else begin
         r_dbCount <= '0;
      end
   end

   // Occupancy state machine; outputs are registered alongside the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= IDLE;
         r_timer        <= '0;
         r_lightsOn     <= 1'b0;
         r_occupied     <= 1'b0;
         r_timeoutPulse <= 1'b0;
      end else begin
         r_timeoutPulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_filtered) begin
                  r_state    <= ACTIVE;
                  r_occupied <= 1'b1;
                  r_lightsOn <= lightDrive(i_mode, 1'b1);
               end else begin
                  r_occupied <= 1'b0;
                  r_lightsOn <= lightDrive(i_mode, 1'b0);
               end
            end
            ACTIVE: begin
               if (!r_filtered) begin
                  r_state <= HOLD;
                  r_timer <= HOLD_LOAD;
               end
               r_occupied <= 1'b1;
               r_lightsOn <= lightDrive(i_mode, 1'b1);
            end
            HOLD: begin
               if (r_filtered) begin
                  r_state    <= ACTIVE;
                  r_occupied <= 1'b1;
                  r_lightsOn <= lightDrive(i_mode, 1'b1);
               end else if (i_tick && (r_timer == TIMER_ONE)) begin
                  r_state        <= IDLE;
                  r_timeoutPulse <= 1'b1;
                  r_occupied     <= 1'b0;
                  r_lightsOn     <= lightDrive(i_mode, 1'b0);
               end else begin
                  if (i_tick) begin
                     r_timer <= r_timer - 1'b1;
                  end
                  r_occupied <= 1'b1;
                  r_lightsOn <= lightDrive(i_mode, 1'b1);
               end
            end
            default: begin
               r_state    <= IDLE;
               r_occupied <= 1'b0;
               r_lightsOn <= lightDrive(i_mode, 1'b0);
            end
         endcase
      end
   end

   assign o_lights_on     = r_lightsOn;
   assign o_occupied      = r_occupied;
   assign o_timeout_pulse = r_timeoutPulse;

endmodule

// File: rtl/motion_zone_controller.sv
// Multi-zone motion lighting controller: a shared hold-timer tick
// prescaler feeding NUM_ZONES independent zone controllers.
module motion_zone_controller #(
   parameter int NUM_ZONES       = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 1000,
   parameter int HOLD_TICKS      = 30,
   parameter int TIMER_W         = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_ZONES-1:0]   i_motion_sensor,
   input  logic [2*NUM_ZONES-1:0] i_override_mode,
   output logic [NUM_ZONES-1:0]   o_lights_on,
   output logic [NUM_ZONES-1:0]   o_occupied,
   output logic [NUM_ZONES-1:0]   o_timeout_pulse,
   output logic                   o_any_occupied
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] r_prescale;
   logic             w_tick;

   assign w_tick = (r_prescale == PRE_LAST);

   // Free-running prescaler; its terminal count is the shared timer tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prescale <= '0;
      end else if (w_tick) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_ZONES; g++) begin : gZone
      motion_zone #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_TICKS      (HOLD_TICKS),
         .TIMER_W         (TIMER_W)
      ) uZone (
         .i_clk           (i_clk),
         .i_rst_n         (i_rst_n),
         .i_tick          (w_tick),
         .i_motion        (i_motion_sensor[g]),
         .i_mode          (i_override_mode[2*g+1:2*g]),
         .o_lights_on     (o_lights_on[g]),
         .o_occupied      (o_occupied[g]),
         .o_timeout_pulse (o_timeout_pulse[g])
      );
   end

   assign o_any_occupied = |o_occupied;

endmodule
